router_inject_ni: RTL
=====================

# router_inject_ni

Network-interface transmitter that injects packets into one router input port and tracks the router's credit-based flow control. It sits between a host message source and a router's `channel_in_ip` and `flow_ctrl_in_op` slice. It packetizes each host message into one head flit plus 1–8 body flits, the last body flit marked tail. Each flit is sent only when the router has advertised buffer space.

## Interface
- `CHANNEL_WIDTH`, 34, flit width of one router port.
- `ROUTER_ADDR_WIDTH`, 4, width of a router address.
- `NUM_CREDITS`, 4, depth of the router input buffer. This is the initial credit count, 1..15.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset. It is asserted when low.
- `src_address` in [0:ROUTER_ADDR_WIDTH-1]: this node's address, quasi-static.
- `msg_valid` in 1: host offers a message header.
- `msg_ready` out 1: header accepted when `msg_valid` and `msg_ready` are both high.
- `msg_dest` in [0:ROUTER_ADDR_WIDTH-1]: destination router address.
- `msg_len` in [0:2]: number of body flits minus 1, so 0 means 1 flit and 7 means 8 flits.
- `data_valid` in 1: host offers one body word.
- `data_ready` out 1: word accepted when `data_valid` and `data_ready` are both high.
- `data` in [0:CHANNEL_WIDTH-4]: 31-bit body payload.
- `flow_ctrl_in` in 1: credit return from the router, one credit per high cycle.
- `channel_out` out [0:CHANNEL_WIDTH-1]: flit to the router.
- `credit_count` out [0:3]: current credits, for debug.
- `error` out 1: sticky credit-overflow flag.

## Operation
Flit format:
- Bit 0 is valid, bit 1 is head, bit 2 is tail, and bits [3:33] are payload.
- Head flit payload carries:
  - bits [3:6]: `msg_dest`
  - bits [7:10]: `src_address`
  - bits [11:13]: `msg_len`
  - all remaining payload bits zero.
- Body flit payload is `data`.
- When no flit is sent, `channel_out` is all zeros.

State machine (IDLE, HEAD, BODY):
- **IDLE:** `msg_ready` = 1. On handshake, latch `msg_dest` and `msg_len`, load the remaining-body counter with `msg_len`, and go to HEAD.
- **HEAD:** if `credit_count` ≠ 0, emit the head flit and go to BODY. Otherwise stall in HEAD.
- **BODY:** `data_ready` = (`credit_count` ≠ 0). Each data handshake emits one body flit.
  - If the remaining count is 0, the flit carries tail = 1 and the FSM returns to IDLE.
  - Otherwise the remaining count decrements.
- `msg_ready` is 0 outside IDLE. `data_ready` is 0 outside BODY.

Credit counter:
- Width 4 bits. Reset value is `NUM_CREDITS`.
- Decrements by 1 on each emitted flit and increments by 1 on each `flow_ctrl_in` cycle.
- If both happen in the same cycle, the count is unchanged.
- A flit is never emitted with `credit_count` = 0.
- If `flow_ctrl_in` = 1, no flit is sent, and the count is already `NUM_CREDITS`:
  - the count holds at `NUM_CREDITS`;
  - `error` sets to 1 and stays set until reset.

Reset behaviour:
- Reset asserted mid-packet aborts the packet; no tail flit is sent.
- The attached router shares this reset.
- Reset values: state IDLE, `channel_out` = 0, `credit_count` = `NUM_CREDITS`, `error` = 0, `msg_ready` = 1, `data_ready` = 0.

## Timing
- `channel_out`, `credit_count` and `error` are registered. `msg_ready` and `data_ready` are decoded from registered state and count only; they have no combinational path from inputs.
- Latencies:
  - Header handshake in cycle N: head flit appears at N+2 if credits are available. The FSM enters HEAD at N+1, and HEAD emits registered at N+2.
  - Data handshake in cycle N: body flit appears at N+1.
- Throughput: one flit per cycle while credits are nonzero. A back-to-back message can be accepted in the cycle after the tail handshake.
- A credit returned in cycle N raises `credit_count` at N+1. A stalled `data_ready` therefore rises at N+1.
- `channel_out` bit 0 is high for exactly one cycle per flit.

## Test plan
- **Single message:** `NUM_CREDITS`=4, `src_address`=0x3, message dest=0x9, len=1 (2 body flits), data 0x1234, 0x5678, no credit returns.
  - Expect a head flit with payload dest 9, src 3, len 1.
  - Then body 0x1234 (tail 0), then body 0x5678 (tail 1).
  - `credit_count` ends at 1; `msg_ready` is high the cycle after the tail.
- **Credit stall:** `NUM_CREDITS`=2, len=3.
  - After head + 1 body, `data_ready`=0 and `channel_out`=0 while credits are 0.
  - A `flow_ctrl_in` pulse at cycle N makes `data_ready` = 1 at N+1.
- **Simultaneous send and credit return:** send a flit while `flow_ctrl_in`=1 → `credit_count` unchanged.
- **Credit overflow:** `flow_ctrl_in` pulse at reset count 4 → `error`=1 next cycle; `credit_count` stays 4; `error` persists until reset.
- **Maximum length:** len=7 → 1 head + 8 body flits, tail set only on the 8th.
- **Reset mid-packet:** assert `reset` low during BODY.
  - All outputs return to reset values asynchronously.
  - After release, a new message starts cleanly with a head flit.

Source files
------------

// File: rtl/router_inject_ni.sv
// ---------------------------------------------------------------------------
// router_inject_ni
//
// Network-interface transmitter. It packetizes one host message into one head
// flit followed by 1..8 body flits, with the last body flit marked tail. It
// injects the flits into a router input port and honours the router's
// credit-based flow control.
//
// Flit layout (bit index = channel_out bit):
//   [0] valid, [1] head, [2] tail, [CHANNEL_WIDTH-1:3] payload
//   head payload: [3 +: AW] dest, [3+AW +: AW] src, [3+2*AW +: 3] len,
//                 all other payload bits zero
//   body payload: host data word
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   src_address   this node's router address (quasi-static)
//   msg_valid     host offers a message header
//   msg_ready     header accepted while high (IDLE only)
//   msg_dest      destination router address
//   msg_len       body flit count minus one
//   data_valid    host offers one body word
//   data_ready    body word accepted while high (BODY with credit)
//   data          body payload word
//   flow_ctrl_in  one returned credit per high cycle
//   channel_out   registered flit to the router (all zeros when idle)
//   credit_count  current credit count
//   error         sticky credit-overflow flag
// ---------------------------------------------------------------------------
module router_inject_ni #(
    parameter int CHANNEL_WIDTH     = 34,
    parameter int ROUTER_ADDR_WIDTH = 4,
    parameter int NUM_CREDITS       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ROUTER_ADDR_WIDTH-1:0] src_address,
    input  logic                         msg_valid,
    output logic                         msg_ready,
    input  logic [ROUTER_ADDR_WIDTH-1:0] msg_dest,
    input  logic [2:0]                   msg_len,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic [CHANNEL_WIDTH-4:0]     data,
    input  logic                         flow_ctrl_in,
    output logic [CHANNEL_WIDTH-1:0]     channel_out,
    output logic [3:0]                   credit_count,
    output logic                         error
);

    localparam int PAYLOAD_W = CHANNEL_WIDTH - 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    localparam logic [3:0] CREDIT_MAX = 4'(NUM_CREDITS);

    logic [1:0]                   r_state;
    logic [2:0]                   r_remain;
    logic [3:0]                   r_credit;
    logic                         r_error;
    logic [CHANNEL_WIDTH-1:0]     r_channel;
    logic [ROUTER_ADDR_WIDTH-1:0] r_dest;
    logic [2:0]                   r_len;

    logic                         w_has_credit;
    logic                         w_msg_hs;
    logic                         w_data_hs;
    logic                         w_head_send;
    logic                         w_send;
    logic                         w_last;
    logic [PAYLOAD_W-1:0]         w_head_payload;

    // Ready signals depend only on registered state and count, never on inputs.
    assign w_has_credit = (r_credit != 4'd0);
    assign msg_ready    = (r_state == ST_IDLE);
    assign data_ready   = (r_state == ST_BODY) && w_has_credit;

    assign w_msg_hs     = msg_valid && msg_ready;
    assign w_data_hs    = data_valid && data_ready;
    assign w_head_send  = (r_state == ST_HEAD) && w_has_credit;
    assign w_send       = w_head_send || w_data_hs;
    assign w_last       = (r_remain == 3'd0);

    always_comb begin
        w_head_payload = '0;
        w_head_payload[ROUTER_ADDR_WIDTH-1:0]                   = r_dest;
        w_head_payload[2*ROUTER_ADDR_WIDTH-1:ROUTER_ADDR_WIDTH] = src_address;
        w_head_payload[2*ROUTER_ADDR_WIDTH+2:2*ROUTER_ADDR_WIDTH] = r_len;
    end

    // Header fields are plain data; they are only consumed after being loaded.
    always_ff @(posedge clk) begin
        if (w_msg_hs) begin
            r_dest <= msg_dest;
            r_len  <= msg_len;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_remain  <= 3'd0;
            r_credit  <= CREDIT_MAX;
            r_error   <= 1'b0;
            r_channel <= '0;
        end else begin
            // Output flit register: a flit lives for exactly one cycle.
            r_channel <= '0;
            if (w_head_send) begin
                r_channel <= {w_head_payload, 1'b0, 1'b1, 1'b1};
            end else if (w_data_hs) begin
                r_channel <= {data, w_last, 1'b0, 1'b1};
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_msg_hs) begin
                        r_remain <= msg_len;
                        r_state  <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (w_head_send) begin
                        r_state <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (w_data_hs) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_remain <= r_remain - 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A send and a credit return in the same cycle cancel out. A
            // return with nothing outstanding is a protocol error: hold the
            // count and flag it until reset.
            case ({w_send, flow_ctrl_in})
                2'b10: r_credit <= r_credit - 4'd1;
                2'b01: begin
                    if (r_credit == CREDIT_MAX) begin
                        r_error <= 1'b1;
                    end else begin
                        r_credit <= r_credit + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign channel_out  = r_channel;
    assign credit_count = r_credit;
    assign error        = r_error;

endmodule
